// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states, opcodes,
// instruction classes and datapath select codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StIExec   = 4'd8,
    StIWb     = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StJal     = 4'd12,
    StJr      = 4'd13,
    StHalt    = 4'd14
  } state_e;

  typedef enum logic [3:0] {
    ClsR, ClsLw, ClsSw, ClsBeq, ClsAddi, ClsSlti, ClsJ, ClsJal, ClsJr, ClsNone
  } instr_class_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001001;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpJr    = 6'b000110;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;
  localparam logic [1:0] AluOpSlt   = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcReg    = 2'b11;

  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  localparam logic [1:0] MemToRegAlu = 2'b00;
  localparam logic [1:0] MemToRegMem = 2'b01;
  localparam logic [1:0] MemToRegPc  = 2'b10;

  localparam logic [1:0] AluSrcBReg   = 2'b00;
  localparam logic [1:0] AluSrcBFour  = 2'b01;
  localparam logic [1:0] AluSrcBImm   = 2'b10;
  localparam logic [1:0] AluSrcBImmSh = 2'b11;

  // States that wait on the memory handshake and run the timeout counter.
  function automatic logic is_mem_wait(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Maps the 6-bit opcode to an instruction class and a legal flag.
module mc_opcode_decode
  import multicycle_controller_pkg::*;
#(
  parameter bit EnableJr = 1'b1
) (
  input  logic [5:0]   opcode,
  output instr_class_e instr_class,
  output logic         legal
);

  always_comb begin
    instr_class = ClsNone;
    legal       = 1'b1;
    case (opcode)
      OpRType: instr_class = ClsR;
      OpLw:    instr_class = ClsLw;
      OpSw:    instr_class = ClsSw;
      OpBeq:   instr_class = ClsBeq;
      OpAddi:  instr_class = ClsAddi;
      OpSlti:  instr_class = ClsSlti;
      OpJ:     instr_class = ClsJ;
      OpJal:   instr_class = ClsJal;
      OpJr: begin
        instr_class = EnableJr ? ClsJr : ClsNone;
        legal       = EnableJr;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM with memory wait/timeout handling and sticky
// error flags; outputs are decoded from the current state.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned ENABLE_JR   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e       state_q, state_d;
  instr_class_e class_q, class_d;
  logic [7:0]   wait_cnt_q, wait_cnt_d;
  logic         illegal_q, illegal_d;
  logic         mem_err_q, mem_err_d;
  logic         timeout;

  instr_class_e dec_class;
  logic         dec_legal;

  mc_opcode_decode #(
    .EnableJr (ENABLE_JR != 0)
  ) u_opcode_decode (
    .opcode      (opcode),
    .instr_class (dec_class),
    .legal       (dec_legal)
  );

  assign timeout = (wait_cnt_q == TimeoutCnt) && !mem_ready;

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d   = StHalt;
          mem_err_d = 1'b1;
        end
      end
      StDecode: begin
        class_d = dec_class;
        if (!dec_legal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          case (dec_class)
            ClsR:             state_d = StRExec;
            ClsLw, ClsSw:     state_d = StMemAddr;
            ClsBeq:           state_d = StBranch;
            ClsAddi, ClsSlti: state_d = StIExec;
            ClsJ:             state_d = StJump;
            ClsJal:           state_d = StJal;
            ClsJr:            state_d = StJr;
            default: begin
              illegal_d = 1'b1;
              state_d   = StHalt;
            end
          endcase
        end
      end
      StMemAddr: state_d = (class_q == ClsSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          state_d   = StHalt;
          mem_err_d = 1'b1;
        end
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
        end else if (timeout) begin
          state_d   = StHalt;
          mem_err_d = 1'b1;
        end
      end
      StRExec: state_d = StRWb;
      StIExec: state_d = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump, StJal, StJr: state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  // Any state change clears the counter, which covers entry into every wait state.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (is_mem_wait(state_q) && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      class_q    <= ClsNone;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    reg_dst    = RegDstRt;
    mem_to_reg = MemToRegAlu;
    alu_src_b  = AluSrcBReg;
    pc_src     = PcSrcAlu;
    alu_op     = AluOpAdd;
    instr_done = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = AluSrcBFour;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: alu_src_b = AluSrcBImmSh;
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = AluSrcBImm;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = MemToRegMem;
        instr_done = 1'b1;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = AluOpFunct;
      end
      StRWb: begin
        reg_write  = 1'b1;
        reg_dst    = RegDstRd;
        instr_done = 1'b1;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = AluSrcBImm;
        alu_op    = (class_q == ClsSlti) ? AluOpSlt : AluOpAdd;
      end
      StIWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_op     = AluOpSub;
        pc_src     = PcSrcAluOut;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      StJump: begin
        pc_src     = PcSrcJump;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      StJal: begin
        pc_src     = PcSrcJump;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = RegDstRa;
        mem_to_reg = MemToRegPc;
        instr_done = 1'b1;
      end
      StJr: begin
        pc_src     = PcSrcReg;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign mem_err    = mem_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: dut_a uses default parameters, dut_b uses MEM_TIMEOUT=4, ENABLE_JR=0;
// both share the same stimulus.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       a_pc_write, a_ir_write, a_i_or_d, a_mem_read, a_mem_write, a_reg_write;
  logic       a_alu_src_a, a_instr_done, a_illegal_op, a_mem_err;
  logic [1:0] a_reg_dst, a_mem_to_reg, a_alu_src_b, a_pc_src, a_alu_op;
  logic [3:0] a_state;
  logic       b_pc_write, b_ir_write, b_i_or_d, b_mem_read, b_mem_write, b_reg_write;
  logic       b_alu_src_a, b_instr_done, b_illegal_op, b_mem_err;
  logic [1:0] b_reg_dst, b_mem_to_reg, b_alu_src_b, b_pc_src, b_alu_op;
  logic [3:0] b_state;

  int n_vec = 0;
  int n_err = 0;

  multicycle_controller dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(a_pc_write), .ir_write(a_ir_write), .i_or_d(a_i_or_d), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .reg_write(a_reg_write), .alu_src_a(a_alu_src_a),
    .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .alu_src_b(a_alu_src_b),
    .pc_src(a_pc_src), .alu_op(a_alu_op), .instr_done(a_instr_done),
    .illegal_op(a_illegal_op), .mem_err(a_mem_err), .state(a_state)
  );

  multicycle_controller #(
    .MEM_TIMEOUT (4),
    .ENABLE_JR   (0)
  ) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .ir_write(b_ir_write), .i_or_d(b_i_or_d), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .reg_write(b_reg_write), .alu_src_a(b_alu_src_a),
    .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .alu_src_b(b_alu_src_b),
    .pc_src(b_pc_src), .alu_op(b_alu_op), .instr_done(b_instr_done),
    .illegal_op(b_illegal_op), .mem_err(b_mem_err), .state(b_state)
  );

  // {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a}
  wire [6:0] a_strb = {a_pc_write, a_ir_write, a_i_or_d, a_mem_read, a_mem_write, a_reg_write,
                       a_alu_src_a};
  wire [6:0] b_strb = {b_pc_write, b_ir_write, b_i_or_d, b_mem_read, b_mem_write, b_reg_write,
                       b_alu_src_a};
  // {reg_dst, mem_to_reg, alu_src_b, pc_src, alu_op}
  wire [9:0] a_sel = {a_reg_dst, a_mem_to_reg, a_alu_src_b, a_pc_src, a_alu_op};
  wire [9:0] b_sel = {b_reg_dst, b_mem_to_reg, b_alu_src_b, b_pc_src, b_alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic expect_st(input bit on_b, input string tag, input state_e st,
                           input logic [6:0] strb, input logic [9:0] sel, input logic done);
    check_eq({tag, ".state"}, 16'(on_b ? b_state : a_state), 16'(st));
    check_eq({tag, ".strb"},  16'(on_b ? b_strb : a_strb), 16'(strb));
    check_eq({tag, ".sel"},   16'(on_b ? b_sel : a_sel), 16'(sel));
    check_eq({tag, ".done"},  16'(on_b ? b_instr_done : a_instr_done), 16'(done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Hand-computed output vectors per state.
  localparam logic [6:0] SbFetchRdy  = 7'b1101000;
  localparam logic [6:0] SbFetchWait = 7'b0001000;
  localparam logic [6:0] SbNone      = 7'b0000000;
  localparam logic [6:0] SbAluA      = 7'b0000001;
  localparam logic [6:0] SbRegWr     = 7'b0000010;
  localparam logic [6:0] SbMemRd     = 7'b0011000;
  localparam logic [6:0] SbMemWr     = 7'b0010100;
  localparam logic [6:0] SbBrTaken   = 7'b1000001;
  localparam logic [6:0] SbPcWr      = 7'b1000000;
  localparam logic [6:0] SbJal       = 7'b1000010;

  localparam logic [9:0] SlFetch   = 10'b00_00_01_00_00;
  localparam logic [9:0] SlDecode  = 10'b00_00_11_00_00;
  localparam logic [9:0] SlRExec   = 10'b00_00_00_00_10;
  localparam logic [9:0] SlRWb     = 10'b01_00_00_00_00;
  localparam logic [9:0] SlImmAdd  = 10'b00_00_10_00_00;
  localparam logic [9:0] SlImmSlt  = 10'b00_00_10_00_11;
  localparam logic [9:0] SlMemWb   = 10'b00_01_00_00_00;
  localparam logic [9:0] SlZero    = 10'b00_00_00_00_00;
  localparam logic [9:0] SlBranch  = 10'b00_00_00_01_01;
  localparam logic [9:0] SlJump    = 10'b00_00_00_10_00;
  localparam logic [9:0] SlJal     = 10'b10_10_00_10_00;
  localparam logic [9:0] SlJr      = 10'b00_00_00_11_00;

  initial begin
    rst       = 1'b1;
    opcode    = OpRType;
    zero      = 1'b0;
    mem_ready = 1'b0;
    do_reset();

    expect_st(0, "rst_a", StFetch, SbFetchWait, SlFetch, 1'b0);
    check_eq("rst_a.illegal", 16'(a_illegal_op), 16'd0);
    check_eq("rst_a.mem_err", 16'(a_mem_err), 16'd0);
    expect_st(1, "rst_b", StFetch, SbFetchWait, SlFetch, 1'b0);

    // R-type add; opcode is garbled after DECODE and must be ignored
    mem_ready = 1'b1;
    #1;
    expect_st(0, "add.fetch", StFetch, SbFetchRdy, SlFetch, 1'b0);
    tick(); expect_st(0, "add.decode", StDecode, SbNone, SlDecode, 1'b0);
    tick(); expect_st(0, "add.exec", StRExec, SbAluA, SlRExec, 1'b0);
    opcode = 6'b111111;
    tick(); expect_st(0, "add.wb", StRWb, SbRegWr, SlRWb, 1'b1);
    tick(); expect_st(0, "add.next", StFetch, SbFetchRdy, SlFetch, 1'b0);

    // lw with three wait cycles in MEM_RD
    opcode = OpLw;
    tick(); expect_st(0, "lw.decode", StDecode, SbNone, SlDecode, 1'b0);
    tick(); expect_st(0, "lw.addr", StMemAddr, SbAluA, SlImmAdd, 1'b0);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_st(0, $sformatf("lw.rd%0d", i), StMemRd, SbMemRd, SlZero, 1'b0);
      check_eq($sformatf("lw.rd%0d_b", i), 16'(b_state), 16'(StMemRd));
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    expect_st(0, "lw.wb", StMemWb, SbRegWr, SlMemWb, 1'b1);
    check_eq("lw.err_a", 16'(a_mem_err), 16'd0);
    check_eq("lw.err_b", 16'(b_mem_err), 16'd0);
    tick(); expect_st(0, "lw.next", StFetch, SbFetchRdy, SlFetch, 1'b0);

    // sw, one wait cycle in MEM_WR
    opcode = OpSw;
    tick(); tick(); expect_st(0, "sw.addr", StMemAddr, SbAluA, SlImmAdd, 1'b0);
    mem_ready = 1'b0;
    tick(); expect_st(0, "sw.wait", StMemWr, SbMemWr, SlZero, 1'b0);
    mem_ready = 1'b1;
    #1;
    expect_st(0, "sw.wr", StMemWr, SbMemWr, SlZero, 1'b1);
    tick(); check_eq("sw.next", 16'(a_state), 16'(StFetch));

    // beq not taken, then taken
    opcode = OpBeq;
    zero   = 1'b0;
    tick(); tick(); expect_st(0, "beq0", StBranch, SbAluA, SlBranch, 1'b1);
    tick(); check_eq("beq0.next", 16'(a_state), 16'(StFetch));
    zero = 1'b1;
    tick(); tick(); expect_st(0, "beq1", StBranch, SbBrTaken, SlBranch, 1'b1);
    tick(); check_eq("beq1.next", 16'(a_state), 16'(StFetch));
    zero = 1'b0;

    // addi / slti: alu_op comes from the class latched in DECODE
    opcode = OpAddi;
    tick(); tick();
    opcode = OpSlti;
    #1;
    expect_st(0, "addi.exec", StIExec, SbAluA, SlImmAdd, 1'b0);
    tick(); expect_st(0, "addi.wb", StIWb, SbRegWr, SlZero, 1'b1);
    tick(); tick(); tick();
    opcode = OpAddi;
    #1;
    expect_st(0, "slti.exec", StIExec, SbAluA, SlImmSlt, 1'b0);
    tick(); expect_st(0, "slti.wb", StIWb, SbRegWr, SlZero, 1'b1);
    tick();

    // j, jal
    opcode = OpJ;
    tick(); tick(); expect_st(0, "j", StJump, SbPcWr, SlJump, 1'b1);
    tick();
    opcode = OpJal;
    tick(); tick(); expect_st(0, "jal", StJal, SbJal, SlJal, 1'b1);
    tick();

    // jr: legal on dut_a, illegal on dut_b
    opcode = OpJr;
    tick(); tick();
    expect_st(0, "jr", StJr, SbPcWr, SlJr, 1'b1);
    expect_st(1, "jr_off", StHalt, SbNone, SlZero, 1'b0);
    check_eq("jr_off.illegal", 16'(b_illegal_op), 16'd1);
    check_eq("jr.illegal_a", 16'(a_illegal_op), 16'd0);
    tick(); check_eq("jr.next", 16'(a_state), 16'(StFetch));

    // illegal opcode halts and holds
    opcode = 6'b111111;
    tick(); tick();
    expect_st(0, "ill", StHalt, SbNone, SlZero, 1'b0);
    check_eq("ill.flag", 16'(a_illegal_op), 16'd1);
    tick(); tick(); tick();
    expect_st(0, "ill.hold", StHalt, SbNone, SlZero, 1'b0);
    check_eq("ill.err", 16'(a_mem_err), 16'd0);
    do_reset();
    expect_st(0, "ill.rst", StFetch, SbFetchRdy, SlFetch, 1'b0);
    check_eq("ill.rst_flag_a", 16'(a_illegal_op), 16'd0);
    check_eq("ill.rst_flag_b", 16'(b_illegal_op), 16'd0);

    // reset wins mid-access
    opcode = OpLw;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick(); check_eq("mid.rd", 16'(a_state), 16'(StMemRd));
    do_reset();
    expect_st(0, "mid.rst", StFetch, SbFetchWait, SlFetch, 1'b0);

    // dut_b timeout in FETCH: counter 0..4 stays, error on the fifth wait cycle
    repeat (4) tick();
    check_eq("to.pre_state", 16'(b_state), 16'(StFetch));
    check_eq("to.pre_err", 16'(b_mem_err), 16'd0);
    tick();
    expect_st(1, "to.halt", StHalt, SbNone, SlZero, 1'b0);
    check_eq("to.err", 16'(b_mem_err), 16'd1);
    check_eq("to.a_waiting", 16'(a_state), 16'(StFetch));
    do_reset();
    check_eq("to.rst_state", 16'(b_state), 16'(StFetch));
    check_eq("to.rst_err", 16'(b_mem_err), 16'd0);

    // mem_ready in the timeout cycle wins
    repeat (4) tick();
    mem_ready = 1'b1;
    tick();
    check_eq("to_win.state", 16'(b_state), 16'(StDecode));
    check_eq("to_win.err", 16'(b_mem_err), 16'd0);

    // default timeout of 16 on dut_a
    mem_ready = 1'b0;
    do_reset();
    repeat (16) tick();
    check_eq("to16.pre", 16'(a_state), 16'(StFetch));
    tick();
    check_eq("to16.halt", 16'(a_state), 16'(StHalt));
    check_eq("to16.err", 16'(a_mem_err), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of wait cycles for mem_ready per memory access (range 1..255).
REQ-002 The block SHALL have parameter ENABLE_JR, default 1, meaning 1 decodes opcode 6'b000110 as jr and 0 treats it as illegal.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 opcode  input  6  instruction opcode field, taken from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access-complete handshake.
REQ-008 pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a  output  1 each  datapath strobes and selects.
REQ-009 reg_dst, mem_to_reg, alu_src_b, pc_src, alu_op  output  2 each  datapath selects (reg_dst: 0=rt 1=rd 2=r31; mem_to_reg: 0=ALU 1=mem 2=PC).
REQ-010 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-011 illegal_op, mem_err  output  1 each  sticky error flags.
REQ-012 state  output  4  current FSM state encoding, for debug.

Function
REQ-013 The FSM SHALL use these states: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, HALT.
REQ-014 All outputs SHALL be Moore-decoded from state, except pc_write and ir_write in FETCH, pc_write in BRANCH, and instr_done, which are also gated by mem_ready or zero.
REQ-015 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_src=00.
REQ-016 In FETCH, ir_write and pc_write SHALL be asserted only in the cycle mem_ready=1; the FSM then goes to DECODE, otherwise it stays in FETCH.
REQ-017 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=00 (branch target).
REQ-018 From DECODE the FSM SHALL branch on opcode: 000000 to R_EXEC; 100011 or 101011 to MEM_ADDR; 000100 to BRANCH; 001001 or 001010 to I_EXEC; 000010 to JUMP; 000011 to JAL; 000110 to JR if ENABLE_JR=1; all others set illegal_op and go to HALT.
REQ-019 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10; R_WB SHALL drive reg_write=1, reg_dst=01 and mem_to_reg=00.
REQ-020 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEM_RD for lw or MEM_WR for sw.
REQ-021 MEM_RD SHALL drive mem_read=1 and i_or_d=1 and advance to MEM_WB on mem_ready.
REQ-022 MEM_WB SHALL drive reg_write=1, reg_dst=00 and mem_to_reg=01.
REQ-023 MEM_WR SHALL drive mem_write=1 and i_or_d=1, and SHALL retire on mem_ready.
REQ-024 I_EXEC SHALL drive alu_src_a=1 and alu_src_b=10, with alu_op=00 for addi and alu_op=11 for slti; I_WB SHALL drive reg_write=1, reg_dst=00 and mem_to_reg=00.
REQ-025 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01 and pc_src=01, with pc_write=zero.
REQ-026 JUMP SHALL drive pc_src=10 and pc_write=1.
REQ-027 JAL SHALL drive pc_src=10, pc_write=1, reg_write=1, reg_dst=10 and mem_to_reg=10.
REQ-028 JR SHALL drive pc_src=11 and pc_write=1.
REQ-029 R_WB, MEM_WB, I_WB, BRANCH, JUMP, JAL, JR and MEM_WR (on mem_ready) SHALL pulse instr_done and return to FETCH next cycle.
REQ-030 Latency SHALL be, with zero wait states: lw 5, sw 4, R/addi/slti 4, beq/j/jal/jr 3 cycles.
REQ-031 An 8-bit wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each cycle in which mem_ready=0 in those states.
REQ-032 When the wait counter equals MEM_TIMEOUT with mem_ready=0, the block SHALL set mem_err and go to HALT.
REQ-033 mem_ready=1 in the timeout cycle SHALL win: the FSM advances normally and no error is raised.
REQ-034 HALT SHALL deassert all strobes and hold until reset.
REQ-035 The opcode SHALL be sampled only in DECODE; changes in other states SHALL be ignored.

Reset
REQ-036 While rst=1 at a clk edge, state SHALL become FETCH, the wait counter 0, and illegal_op=mem_err=0.
REQ-037 Reset SHALL take priority over every transition, including mid-access and HALT.
REQ-038 In the first cycle after reset, outputs SHALL equal the FETCH decode, and instr_done SHALL be 0.

Structure
REQ-039 A shared package SHALL hold the state enum, the opcode constants, and the alu_op, pc_src, reg_dst and mem_to_reg encodings.
REQ-040 One sub-module, mc_opcode_decode, SHALL map opcode to an instruction class plus a legal flag; the FSM, counter and output decode SHALL stay in multicycle_controller.

Verification
REQ-041 Reset, then add (000000), mem_ready=1 constantly -> states FETCH,DECODE,R_EXEC,R_WB; instr_done in cycle 4; reg_dst=01 in R_WB.
REQ-042 lw (100011) with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles; MEM_WB has reg_write=1 and mem_to_reg=01; no mem_err.
REQ-043 beq (000100), zero=0 and then zero=1 -> pc_write=0 and pc_write=1 respectively in BRANCH; both retire in 3 cycles.
REQ-044 jal (000011) -> JAL with reg_dst=10, mem_to_reg=10, pc_src=10 and reg_write=pc_write=1.
REQ-045 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> mem_err=1 after 4 wait cycles and HALT; rst=1 -> FETCH with flags cleared.
REQ-046 opcode 111111, and opcode 000110 with ENABLE_JR=0 -> illegal_op=1 and HALT, with no pc_write or reg_write asserted.
